// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, flush defaults and
// the bundle of front-end control strobes produced by the hazard unit.
package pipeline_pkg;

  localparam int FLUSH_CYCLES_DEFAULT = 2;
  localparam int FLUSH_CNT_W          = 3;
  localparam int REG_IDX_W            = 4;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id_ex;
    logic invalid_id;
    logic flush_if_id;
    logic pc_redirect;
  } hz_ctrl_t;

  // A source operand conflicts only if the instruction actually reads it.
  function automatic logic src_hit(input logic                 used,
                                   input logic [REG_IDX_W-1:0] rs,
                                   input logic [REG_IDX_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use stall, taken-branch redirect/flush sequencing
// and saturating performance counters for both events.
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] rs1_ID,
  input  logic [REG_IDX_W-1:0] rs2_ID,
  input  logic                 rs1_used_ID,
  input  logic                 rs2_used_ID,
  input  logic [REG_IDX_W-1:0] rd_EX,
  input  logic                 regfile_we_EX,
  input  logic                 load_EX,
  input  logic                 invalid_EX,
  input  logic                 branch_taken_EX,
  output logic                 stall_IF,
  output logic                 stall_ID_EX,
  output logic                 invalid_ID,
  output logic                 flush_IF_ID,
  output logic                 pc_redirect,
  output logic [1:0]           hz_state,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam hz_state_t              BRANCH_NEXT  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  hz_state_t              state, state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt, cnt_nxt;
  hz_ctrl_t               ctrl, ctrl_out;
  logic                   valid_branch;
  logic                   load_use;

  assign valid_branch = branch_taken_EX && !invalid_EX;

  assign load_use = load_EX && regfile_we_EX && !invalid_EX && (rd_EX != '0) &&
                    (src_hit(rs1_used_ID, rs1_ID, rd_EX) ||
                     src_hit(rs2_used_ID, rs2_ID, rd_EX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = flush_cnt;
    ctrl      = '0;
    case (state)
      RUN, LOAD_STALL: begin
        if (valid_branch) begin
          ctrl.pc_redirect = 1'b1;
          ctrl.flush_if_id = 1'b1;
          ctrl.invalid_id  = 1'b1;
          cnt_nxt          = FLUSH_RELOAD;
          state_nxt        = BRANCH_NEXT;
        end else if ((state == RUN) && load_use) begin
          // One bubble is enough: the load data is forwardable next cycle.
          ctrl.stall_if    = 1'b1;
          ctrl.stall_id_ex = 1'b1;
          state_nxt        = LOAD_STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        ctrl.flush_if_id = 1'b1;
        ctrl.invalid_id  = 1'b1;
        if (valid_branch) begin
          ctrl.pc_redirect = 1'b1;
          cnt_nxt          = FLUSH_RELOAD;
          state_nxt        = BRANCH_NEXT;
        end else begin
          cnt_nxt   = (flush_cnt == '0) ? '0 : flush_cnt - FLUSH_CNT_W'(1);
          state_nxt = (flush_cnt <= FLUSH_CNT_W'(1)) ? RUN : FLUSH;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Strobes are combinational on the inputs, so they must be masked in reset.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign stall_IF    = ctrl_out.stall_if;
  assign stall_ID_EX = ctrl_out.stall_id_ex;
  assign invalid_ID  = ctrl_out.invalid_id;
  assign flush_IF_ID = ctrl_out.flush_if_id;
  assign pc_redirect = ctrl_out.pc_redirect;
  assign hz_state    = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl_out.stall_id_ex),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl_out.pc_redirect),
    .count (flush_count)
  );

endmodule
